// File: rtl/dispatch_ctrl.sv
// Credit-based issue gate between ID and ISSUE: tracks ROB/RS/LSB occupancy,
// stalls ID when a needed resource is full, and sequences a one-cycle flush.
module dispatch_ctrl #(
    parameter int ROB_SIZE = 16,
    parameter int RS_SIZE  = 16,
    parameter int LSB_SIZE = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear,
    input  logic             id_valid,
    input  logic             id_is_mem,
    input  logic             rob_commit,
    input  logic             rs_free,
    input  logic             lsb_free,
    input  logic [CNT_W-1:0] lsb_keep,
    output logic             issue_en,
    output logic             id_stall,
    output logic [CNT_W-1:0] rob_cnt,
    output logic [CNT_W-1:0] rs_cnt,
    output logic [CNT_W-1:0] lsb_cnt,
    output logic             cnt_err,
    output logic             state_o
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [CNT_W-1:0] ROB_MAX = CNT_W'(ROB_SIZE);
    localparam logic [CNT_W-1:0] RS_MAX  = CNT_W'(RS_SIZE);
    localparam logic [CNT_W-1:0] LSB_MAX = CNT_W'(LSB_SIZE);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rob_q, rob_d;
    logic [CNT_W-1:0] rs_q, rs_d;
    logic [CNT_W-1:0] lsb_q, lsb_d;
    logic             err_q, err_d;

    // Returns {underflow, next_count}; a net decrement at zero holds the count.
    function automatic logic [CNT_W:0] step(input logic [CNT_W-1:0] cnt,
                                            input logic inc, input logic dec);
        logic [CNT_W:0] r;
        r = {1'b0, cnt};
        if (inc && !dec) begin
            r = {1'b0, cnt + 1'b1};
        end else if (dec && !inc) begin
            if (cnt == '0) r = {1'b1, cnt};
            else           r = {1'b0, cnt - 1'b1};
        end
        return r;
    endfunction

    // Handshake: id_valid is the producer's valid, issue_en is the ready; an
    // instruction transfers exactly in a cycle where both are high. The full
    // check uses registered counts only, so same-cycle frees never unblock.
    always_comb begin
        issue_en = 1'b0;
        if (!rst_in && !clear && rdy_in && state_q == RUN && id_valid &&
            rob_q < ROB_MAX) begin
            issue_en = id_is_mem ? (lsb_q < LSB_MAX) : (rs_q < RS_MAX);
        end
    end

    assign id_stall = id_valid & ~issue_en;

    always_comb begin
        logic [CNT_W:0] rob_s, rs_s, lsb_s;
        state_d = state_q;
        rob_d   = rob_q;
        rs_d    = rs_q;
        lsb_d   = lsb_q;
        err_d   = err_q;
        rob_s   = '0;
        rs_s    = '0;
        lsb_s   = '0;
        if (rdy_in) begin
            if (clear) begin
                state_d = FLUSH;
                rob_d   = '0;
                rs_d    = '0;
                lsb_d   = (lsb_keep > LSB_MAX) ? LSB_MAX : lsb_keep;
            end else if (state_q == FLUSH) begin
                // Committed stores keep draining while the rest is rebuilt.
                state_d = RUN;
                lsb_s   = step(lsb_q, 1'b0, lsb_free);
                lsb_d   = lsb_s[CNT_W-1:0];
                err_d   = err_q | lsb_s[CNT_W];
            end else begin
                rob_s = step(rob_q, issue_en, rob_commit);
                rs_s  = step(rs_q, issue_en & ~id_is_mem, rs_free);
                lsb_s = step(lsb_q, issue_en & id_is_mem, lsb_free);
                rob_d = rob_s[CNT_W-1:0];
                rs_d  = rs_s[CNT_W-1:0];
                lsb_d = lsb_s[CNT_W-1:0];
                err_d = err_q | rob_s[CNT_W] | rs_s[CNT_W] | lsb_s[CNT_W];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= RUN;
            rob_q   <= '0;
            rs_q    <= '0;
            lsb_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rob_q   <= rob_d;
            rs_q    <= rs_d;
            lsb_q   <= lsb_d;
            err_q   <= err_d;
        end
    end

    assign rob_cnt = rob_q;
    assign rs_cnt  = rs_q;
    assign lsb_cnt = lsb_q;
    assign cnt_err = err_q;
    assign state_o = state_q;

endmodule
